// File: rtl/orlink_pkg.sv
// Shared definitions for the orlink byte link: CRC-16 constants, the byte-wise
// CRC update used by both transmit and receive sides, and the payload beat type.
package orlink_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CRC_W  = 16;

    localparam logic [CRC_W-1:0] CRC16_POLY = 16'h1021;
    localparam logic [CRC_W-1:0] CRC16_INIT = 16'h0000;

    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic              last;
    } orlink_beat_t;

    // MSB-first, non-reflected CRC-16 update over one byte.
    function automatic logic [CRC_W-1:0] crc16_update(input logic [CRC_W-1:0] crc,
                                                      input logic [BYTE_W-1:0] data);
        logic [CRC_W-1:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/orlink_crc16_chk.sv
// Running CRC-16 register for received frames; flags a zero residue on the
// value that the current byte would produce.
module orlink_crc16_chk
    import orlink_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              restart,
    input  logic [BYTE_W-1:0] data,
    output logic              res_zero_c
);

    logic [CRC_W-1:0] crc;
    logic [CRC_W-1:0] crc_next_c;

    always_comb begin
        crc_next_c = crc16_update(crc, data);
        res_zero_c = (crc_next_c == CRC_W'(0));
    end

    // Restart takes priority so the frame's last byte leaves the register clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC16_INIT;
        end else if (en) begin
            crc <= restart ? CRC16_INIT : crc_next_c;
        end
    end

endmodule

// File: rtl/orlink_rx_crc_check.sv
// Receive-side frame checker: strips the trailing CRC-16, forwards payload bytes
// through a two-byte hold buffer and reports per-frame status and statistics.
module orlink_rx_crc_check
    import orlink_pkg::*;
#(
    parameter int unsigned MAX_LEN = 1024,
    parameter int unsigned LEN_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              frame_done,
    output logic              frame_ok,
    output logic              frame_runt,
    output logic              frame_oversize,
    output logic [LEN_W-1:0]  frame_len,
    output logic [LEN_W-1:0]  good_cnt,
    output logic [LEN_W-1:0]  bad_cnt
);

    logic              accept_c;
    logic              full_c;
    logic              emit_c;
    logic              end_c;
    logic              res_zero_c;
    logic              oversize_c;
    logic              ok_c;
    logic [1:0]        fill;
    logic [BYTE_W-1:0] h0;
    logic [BYTE_W-1:0] h1;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  len_next_c;
    orlink_beat_t      out_beat;

    assign in_ready = !out_valid || out_ready;
    assign out_data = out_beat.data;
    assign out_last = out_beat.last;

    always_comb begin
        accept_c   = in_valid && in_ready;
        full_c     = (fill == 2'd2);
        emit_c     = accept_c && full_c;
        end_c      = accept_c && in_last;
        len_next_c = len;
        if (emit_c && (len != '1)) begin
            len_next_c = len + LEN_W'(1);
        end
        oversize_c = (len_next_c > LEN_W'(MAX_LEN));
        ok_c       = res_zero_c && full_c && !oversize_c;
    end

    orlink_crc16_chk u_crc (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (accept_c),
        .restart    (in_last),
        .data       (in_data),
        .res_zero_c (res_zero_c)
    );

    // Hold buffer: the two most recent bytes may be the CRC, so they lag the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill <= 2'd0;
            h0   <= '0;
            h1   <= '0;
        end else if (accept_c) begin
            h1 <= h0;
            h0 <= in_data;
            if (in_last) begin
                fill <= 2'd0;
            end else if (!full_c) begin
                fill <= fill + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_beat  <= '0;
        end else if (emit_c) begin
            out_valid     <= 1'b1;
            out_beat.data <= h1;
            out_beat.last <= in_last;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
            out_beat.last <= 1'b0;
        end
    end

    // Per-frame status pulses and saturating statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len            <= '0;
            frame_done     <= 1'b0;
            frame_ok       <= 1'b0;
            frame_runt     <= 1'b0;
            frame_oversize <= 1'b0;
            frame_len      <= '0;
            good_cnt       <= '0;
            bad_cnt        <= '0;
        end else begin
            frame_done     <= end_c;
            frame_ok       <= end_c && ok_c;
            frame_runt     <= end_c && !full_c;
            frame_oversize <= end_c && oversize_c;
            len            <= end_c ? '0 : len_next_c;
            if (end_c) begin
                frame_len <= len_next_c;
                if (ok_c) begin
                    if (good_cnt != '1) good_cnt <= good_cnt + LEN_W'(1);
                end else begin
                    if (bad_cnt != '1) bad_cnt <= bad_cnt + LEN_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_orlink_rx_crc_check.sv
// Directed bench for orlink_rx_crc_check: frame table plus backpressure,
// back-to-back, reset and oversize sequences.
module tb_orlink_rx_crc_check;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic        frame_done, frame_ok, frame_runt, frame_oversize;
    logic [15:0] frame_len, good_cnt, bad_cnt;

    logic        o2_in_ready, o2_out_valid, o2_out_last;
    logic [7:0]  o2_out_data;
    logic        o2_frame_done, o2_frame_ok, o2_frame_runt, o2_frame_oversize;
    logic [15:0] o2_frame_len, o2_good_cnt, o2_bad_cnt;

    always #5 clk = ~clk;

    orlink_rx_crc_check #(.MAX_LEN(1024), .LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .frame_done(frame_done), .frame_ok(frame_ok), .frame_runt(frame_runt),
        .frame_oversize(frame_oversize), .frame_len(frame_len),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    orlink_rx_crc_check #(.MAX_LEN(8), .LEN_W(16)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(o2_in_ready), .out_valid(o2_out_valid),
        .out_data(o2_out_data), .out_last(o2_out_last), .out_ready(out_ready),
        .frame_done(o2_frame_done), .frame_ok(o2_frame_ok), .frame_runt(o2_frame_runt),
        .frame_oversize(o2_frame_oversize), .frame_len(o2_frame_len),
        .good_cnt(o2_good_cnt), .bad_cnt(o2_bad_cnt)
    );

    typedef struct packed {
        logic [11:0][7:0] b;
        logic [3:0]       n;
        logic             ok;
        logic             runt;
        logic [15:0]      len;
        logic             ovs;
        logic [15:0]      good;
        logic [15:0]      bad;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [7:0] q_data[$];
    logic       q_last[$];
    int         done_cyc[$];
    logic        d_ok, d_runt, d_ovs;
    logic [15:0] d_len;
    logic        s_ok, s_ovs;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture transferred beats and frame status away from the active edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_last.push_back(out_last);
        end
        if (rst_n && frame_done) begin
            d_ok = frame_ok; d_runt = frame_runt; d_ovs = frame_oversize; d_len = frame_len;
            done_cyc.push_back(cyc);
            done_cnt++;
        end
        if (rst_n && o2_frame_done) begin
            s_ok = o2_frame_ok; s_ovs = o2_frame_oversize;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        logic acc;
        int   guard;
        in_valid = 1'b1; in_data = d; in_last = last;
        guard = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 200);
        if (!acc) timeout_fail("accept");
    endtask

    task automatic send_frame(input vec_t v, input logic gap);
        for (int i = 0; i < int'(v.n); i++) send_byte(v.b[i], (i == int'(v.n) - 1));
        if (gap) begin
            in_valid = 1'b0; in_last = 1'b0;
        end
    endtask

    task automatic wait_done(input int target);
        int guard;
        guard = 0;
        while (done_cnt < target && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (done_cnt < target) timeout_fail("frame_done");
    endtask

    task automatic check_frame(input string tag, input vec_t v,
                               input logic [15:0] eg, input logic [15:0] eb);
        int nbeats;
        nbeats = v.runt ? 0 : int'(v.n) - 2;
        check({tag, ".ok"}, d_ok, v.ok);
        check({tag, ".runt"}, d_runt, v.runt);
        check({tag, ".oversize"}, d_ovs, 1'b0);
        check({tag, ".len"}, d_len, v.len);
        check({tag, ".good_cnt"}, good_cnt, eg);
        check({tag, ".bad_cnt"}, bad_cnt, eb);
        check({tag, ".beats"}, q_data.size(), nbeats);
        for (int j = 0; j < nbeats && j < q_data.size(); j++) begin
            check({tag, ".data"}, q_data[j], v.b[j]);
            check({tag, ".last"}, q_last[j], (j == nbeats - 1));
        end
        check({tag, ".small_oversize"}, s_ovs, v.ovs);
        check({tag, ".small_ok"}, s_ok, v.ok && !v.ovs);
    endtask

    function automatic vec_t mk(input logic [3:0] n, input logic ok, input logic runt,
                                input logic [15:0] len, input logic ovs,
                                input logic [15:0] g, input logic [15:0] b);
        vec_t v;
        v = '0;
        v.n = n; v.ok = ok; v.runt = runt; v.len = len; v.ovs = ovs; v.good = g; v.bad = b;
        return v;
    endfunction

    vec_t vecs[5];
    vec_t clean;
    logic [7:0] held;

    initial begin
        vecs[0] = mk(4'd11, 1'b1, 1'b0, 16'd9, 1'b1, 16'd1, 16'd0);
        for (int i = 0; i < 9; i++) vecs[0].b[i] = 8'h31 + 8'(i);
        vecs[0].b[9] = 8'h31; vecs[0].b[10] = 8'hC3;
        vecs[1] = vecs[0];
        vecs[1].b[10] = 8'hC4; vecs[1].ok = 1'b0; vecs[1].bad = 16'd1;
        vecs[2] = mk(4'd1, 1'b0, 1'b1, 16'd0, 1'b0, 16'd1, 16'd2);
        vecs[2].b[0] = 8'h55;
        vecs[3] = mk(4'd2, 1'b0, 1'b1, 16'd0, 1'b0, 16'd1, 16'd3);
        vecs[4] = mk(4'd3, 1'b1, 1'b0, 16'd1, 1'b0, 16'd2, 16'd3);
        vecs[4].b[0] = 8'h41; vecs[4].b[1] = 8'h58; vecs[4].b[2] = 8'hE5;
        clean = vecs[0];

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.out_data", out_data, 8'h00);
        check("rst.out_last", out_last, 1'b0);
        check("rst.frame_done", frame_done, 1'b0);
        check("rst.frame_len", frame_len, 16'd0);
        check("rst.in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 5; k++) begin
            q_data.delete(); q_last.delete();
            send_frame(vecs[k], 1'b1);
            wait_done(k + 1);
            repeat (2) @(posedge clk);
            #1;
            check_frame($sformatf("vec%0d", k), vecs[k], vecs[k].good, vecs[k].bad);
        end

        // Backpressure: stall the output for 5 cycles mid-frame.
        q_data.delete(); q_last.delete();
        fork
            send_frame(clean, 1'b1);
            begin
                int guard;
                guard = 0;
                while (q_data.size() < 3 && guard < 100) begin
                    @(posedge clk); #1; guard++;
                end
                if (q_data.size() < 3) timeout_fail("stall_start");
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("stall.in_ready", in_ready, 1'b0);
                    check("stall.out_valid", out_valid, 1'b1);
                    check("stall.out_data", out_data, 8'h34);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_done(6);
        repeat (2) @(posedge clk);
        #1;
        check_frame("stall", clean, 16'd3, 16'd3);

        // Back-to-back clean frames with no idle cycle between them.
        q_data.delete(); q_last.delete(); done_cyc.delete();
        send_frame(clean, 1'b0);
        send_frame(clean, 1'b1);
        wait_done(8);
        repeat (2) @(posedge clk);
        #1;
        check("b2b.beats", q_data.size(), 18);
        check("b2b.good_cnt", good_cnt, 16'd5);
        check("b2b.ok", d_ok, 1'b1);
        if (done_cyc.size() == 2) check("b2b.spacing", done_cyc[1] - done_cyc[0], 11);
        else check("b2b.done_pulses", done_cyc.size(), 2);
        for (int j = 0; j < 18 && j < q_data.size(); j++) begin
            check("b2b.data", q_data[j], clean.b[j % 9]);
            check("b2b.last", q_last[j], (j == 8 || j == 17));
        end

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < 4; i++) send_byte(clean.b[i], 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst.out_valid", out_valid, 1'b0);
        check("mrst.out_data", out_data, 8'h00);
        check("mrst.frame_done", frame_done, 1'b0);
        check("mrst.frame_len", frame_len, 16'd0);
        check("mrst.good_cnt", good_cnt, 16'd0);
        check("mrst.bad_cnt", bad_cnt, 16'd0);
        check("mrst.in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        q_data.delete(); q_last.delete();
        send_frame(clean, 1'b1);
        wait_done(9);
        repeat (2) @(posedge clk);
        #1;
        check_frame("post_rst", clean, 16'd1, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/orlink_rx_crc_check.md
# orlink_rx_crc_check

Receive-side frame checker for the orlink byte link. Accepts a byte stream whose frames end in a 16-bit CRC (high byte first), computes CRC-16 (poly 0x1021, init 0x0000, MSB-first, no reflection, no final XOR) over each frame, strips the two CRC bytes, and forwards payload bytes downstream with a per-frame status pulse. It sits between the link deserializer and the packet parser, mirroring the transmit-side CRC generator.

## Interface
- `MAX_LEN`, 1024: largest legal payload length in bytes; longer frames are flagged oversize.
- `LEN_W`, 16: width of the payload length counter and the frame statistics counters.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input byte valid.
- `in_data`  in  8  input byte.
- `in_last`  in  1  marks the final byte of a frame, which is the CRC low byte.
- `in_ready`  out  1  input accept.
- `out_valid`  out  1  payload byte valid.
- `out_data`  out  8  payload byte.
- `out_last`  out  1  final payload byte of the frame.
- `out_ready`  in  1  downstream accept.
- `frame_done`  out  1  one-cycle pulse at end of frame.
- `frame_ok`  out  1  qualified by `frame_done`: CRC residue zero, not runt, not oversize.
- `frame_runt`  out  1  qualified by `frame_done`: frame shorter than 3 bytes.
- `frame_oversize`  out  1  qualified by `frame_done`: payload length greater than `MAX_LEN`.
- `frame_len`  out  LEN_W  qualified by `frame_done`: payload byte count, saturating.
- `good_cnt`, `bad_cnt`  out  LEN_W each  saturating frame counters.

## Operation
- A byte is accepted when `in_valid && in_ready`, where `in_ready = !out_valid || out_ready`.
- Running CRC register `crc` updates with each accepted byte, CRC bytes included. A frame is good when the updated `crc` equals 0x0000 at `in_last`.
- Two-byte hold buffer `h1` (older) and `h0`, with fill count `fill` in {0, 1, 2}:
  - On accept with `fill == 2`, `h1` is loaded into the output register and the buffer shifts.
  - On accept with `fill < 2`, the byte is stored and `fill` increments.
- `in_last` accepted with `fill == 2`:
  - `h1` is emitted with `out_last = 1`.
  - `h0` and `in_data` are the CRC and are discarded.
- `in_last` accepted with `fill < 2` is a runt:
  - No output beat.
  - `frame_runt = 1`, `frame_ok = 0`.
- On every `in_last` acceptance:
  - `crc` returns to 0x0000 and `fill` returns to 0.
  - The length counter clears.
  - `frame_done` pulses.
  - Exactly one of `good_cnt` / `bad_cnt` increments; both saturate at all-ones.
- The length counter increments per emitted payload byte and saturates at all-ones. It feeds `frame_oversize`.
- If the output register is held and `out_ready` is low, the input stalls. No byte is ever dropped or duplicated.
- Reset mid-frame discards the partial frame. There is no `frame_done` for it, and the next byte starts a new frame.

## Timing
- Reset values:
  - `out_valid`, `out_last`, `frame_done`, `frame_ok`, `frame_runt`, `frame_oversize`: 0.
  - `out_data`: 0x00.
  - `frame_len`, `good_cnt`, `bad_cnt`: 0.
  - `crc`: 0x0000.
  - `fill`: 0.
- `in_ready` is 1 out of reset.
- Latency: payload byte k appears on `out_*` the cycle after byte k+2 is accepted. Output is registered.
- `frame_done` and its qualifiers are asserted the cycle after `in_last` is accepted. This is the same cycle `out_valid && out_last` first appears. They are held for exactly one cycle, independent of `out_ready`.
- Back-to-back frames, with `in_last` then a new byte on the next cycle, sustain 1 byte per cycle with no bubble.
- `out_valid` with `out_ready` low holds `out_data` and `out_last` stable.

## Structure
- Package `orlink_pkg` holds:
  - `CRC16_POLY = 16'h1021`, `CRC16_INIT = 16'h0000`.
  - Function `crc16_update(crc, byte)`, shared with the transmit-side generator.
- One sub-module, `orlink_crc16_chk`: the CRC register with init, byte-enable and zero-residue flag.
- The hold buffer, output register and status logic live in the top module.

## Test plan
- Clean frame: "123456789" followed by 0x31, 0xC3 (`in_last`) -> 9 out beats "123456789", `out_last` on '9', `frame_ok = 1`, `frame_len = 9`, `good_cnt = 1`.
- Corrupt frame: same payload, CRC 0x31, 0xC4 -> 9 payload beats still emitted, `frame_ok = 0`, `bad_cnt = 1`.
- Runts: 1-byte frame and 2-byte frame -> no out beats, `frame_runt = 1` each, `bad_cnt = 2`.
- Backpressure: `out_ready` low for 5 cycles mid-frame -> `in_ready` low during the stall, output byte held stable, full payload intact afterwards.
- Back-to-back plus reset: two clean frames with no gap -> two `frame_ok` pulses 11 cycles apart. Then `rst_n` asserted after 4 bytes of a third frame -> all outputs return to reset values, and the following clean frame passes.
- Oversize: `MAX_LEN = 8`, clean "123456789" frame -> `frame_oversize = 1`, `frame_ok = 0`.
